// File: rtl/fa_using_structural.sv
// Structural 1-bit full adder: two half adders plus an OR gate,
// with combinational outputs and a registered copy of sum/cout.

module fa_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  xor u_xor (s, a, b);
  and u_and (c, a, b);

endmodule

module fa_using_structural #(
  parameter int unsigned GATE_DELAY = 0,
  parameter logic        REG_RESET  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic p,
  output logic g,
  output logic sum_q,
  output logic cout_q
);

  logic t;

  // Gate delay is a simulation-only annotation; synthesized gates are zero-delay.
  if (GATE_DELAY != 0) begin : g_delay_annot
  end

  fa_half_adder ha0 (
    .a (a),
    .b (b),
    .s (p),
    .c (g)
  );

  fa_half_adder ha1 (
    .a (p),
    .b (cin),
    .s (sum),
    .c (t)
  );

  or u_or (cout, g, t);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= REG_RESET;
      cout_q <= REG_RESET;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_fa_using_structural.sv
// Directed bench for fa_using_structural: truth table,
// propagate/generate, registered outputs and async reset.

module tb_fa_using_structural;

  localparam logic RR = 1'b0;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;
  logic p;
  logic g;
  logic sum_q;
  logic cout_q;

  int checks;
  int failures;

  // Hand-written truth table, bit index = {a,b,cin}
  logic [7:0] tt_sum;
  logic [7:0] tt_cout;

  fa_using_structural #(
    .GATE_DELAY (0),
    .REG_RESET  (RR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .p      (p),
    .g      (g),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    {a, b, cin} = 3'b111;
    #1;
    checks++;
    if (sum_q !== RR) begin
      failures++;
      $display("FAIL reset_sum_q got=%b exp=%b", sum_q, RR);
    end
    checks++;
    if (cout_q !== RR) begin
      failures++;
      $display("FAIL reset_cout_q got=%b exp=%b", cout_q, RR);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== RR || cout_q !== RR) begin
      failures++;
      $display("FAIL reset_hold got=%b%b exp=%b%b", cout_q, sum_q, RR, RR);
    end
    checks++;
    if (sum !== 1'b1 || cout !== 1'b1) begin
      failures++;
      $display("FAIL comb_in_reset got=%b%b exp=11", cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_t1();
    {a, b, cin} = 3'b000;
    #1;
    checks++;
    if ({sum, cout, p, g} !== 4'b0000) begin
      failures++;
      $display("FAIL t1_000 got=%b exp=0000", {sum, cout, p, g});
    end
  endtask

  task automatic test_t2();
    {a, b, cin} = 3'b100;
    #1;
    checks++;
    if ({sum, cout} !== 2'b10) begin
      failures++;
      $display("FAIL t2_100 got=%b exp=10", {sum, cout});
    end
    b = 1'b1;
    #1;
    checks++;
    if ({sum, cout, g, p} !== 4'b0110) begin
      failures++;
      $display("FAIL t2_110 got=%b exp=0110", {sum, cout, g, p});
    end
  endtask

  task automatic test_t3();
    {a, b, cin} = 3'b010;
    #1;
    checks++;
    if ({sum, cout} !== 2'b10) begin
      failures++;
      $display("FAIL t3_010 got=%b exp=10", {sum, cout});
    end
    cin = 1'b1;
    #1;
    checks++;
    if ({sum, cout, p, g} !== 4'b0110) begin
      failures++;
      $display("FAIL t3_011 got=%b exp=0110", {sum, cout, p, g});
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] arith;
      v = 3'(i);
      {a, b, cin} = v;
      #1;
      arith = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
      checks++;
      if ({cout, sum} !== arith) begin
        failures++;
        $display("FAIL sweep_arith v=%b got=%b exp=%b", v, {cout, sum}, arith);
      end
      checks++;
      if (sum !== tt_sum[i] || cout !== tt_cout[i]) begin
        failures++;
        $display("FAIL sweep_table v=%b got=%b%b exp=%b%b",
                 v, cout, sum, tt_cout[i], tt_sum[i]);
      end
      checks++;
      if (p !== (v[2] ^ v[1]) || g !== (v[2] & v[1])) begin
        failures++;
        $display("FAIL sweep_pg v=%b got=%b%b exp=%b%b",
                 v, p, g, v[2] ^ v[1], v[2] & v[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    {a, b, cin} = 3'b111;
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q} !== 2'b11) begin
      failures++;
      $display("FAIL t5_capture got=%b exp=11", {sum_q, cout_q});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sum_q !== RR || cout_q !== RR) begin
      failures++;
      $display("FAIL t5_async_clear got=%b%b exp=%b%b", sum_q, cout_q, RR, RR);
    end
    checks++;
    if ({sum, cout} !== 2'b11) begin
      failures++;
      $display("FAIL t5_comb_kept got=%b exp=11", {sum, cout});
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst = 1'b0;
    {a, b, cin} = 3'b011;
    #1;
    checks++;
    if (sum_q !== RR || cout_q !== RR) begin
      failures++;
      $display("FAIL t6_pre_edge got=%b%b exp=%b%b", sum_q, cout_q, RR, RR);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q} !== 2'b01) begin
      failures++;
      $display("FAIL t6_first_edge got=%b exp=01", {sum_q, cout_q});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(7 - i);
      @(negedge clk);
      {a, b, cin} = v;
      #1;
      checks++;
      if (i > 0 && (sum_q !== tt_sum[8 - i] || cout_q !== tt_cout[8 - i])) begin
        failures++;
        $display("FAIL b2b_hold v=%b got=%b%b exp=%b%b",
                 v, cout_q, sum_q, tt_cout[8 - i], tt_sum[8 - i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== tt_sum[7 - i] || cout_q !== tt_cout[7 - i]) begin
        failures++;
        $display("FAIL b2b_capture v=%b got=%b%b exp=%b%b",
                 v, cout_q, sum_q, tt_cout[7 - i], tt_sum[7 - i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tt_sum   = 8'b1001_0110;
    tt_cout  = 8'b1110_1000;
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    cin = 1'b0;
    test_reset();
    test_t1();
    test_t2();
    test_t3();
    test_sweep();
    test_async_reset();
    test_release();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
